// File: rtl/ftb_update_ctrl_pkg.sv
// Shared frontend types for the FTB update path: update payload, FTB entry,
// index/tag helpers and the update-sequencer state encoding.
package ftb_update_ctrl_pkg;

    localparam int unsigned VADDR_WIDTH = 39;

    typedef struct packed {
        logic        valid;
        logic        brValid;
        logic [3:0]  brOffset;
        logic [11:0] brLower;
        logic [3:0]  pftAddr;
        logic        carry;
        logic        isCall;
        logic        isRet;
        logic        isJalr;
    } ftbEntry_t;

    typedef struct packed {
        logic [VADDR_WIDTH-1:0] startAddr;
        ftbEntry_t              ftb_update;
    } BPupdateInfo_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } ftbUpdState_t;

    // Bit 0 of startAddr is the half-word offset, so the set index starts at bit 1.
    virtual class ftbFuncs #(parameter int unsigned IDX_WIDTH = 9,
                             parameter int unsigned TAG_WIDTH = 20);
        static function logic [IDX_WIDTH-1:0] getIdx(input logic [VADDR_WIDTH-1:0] addr);
            return addr[IDX_WIDTH:1];
        endfunction

        static function logic [TAG_WIDTH-1:0] getTag(input logic [VADDR_WIDTH-1:0] addr);
            return addr[IDX_WIDTH+TAG_WIDTH:IDX_WIDTH+1];
        endfunction
    endclass

endpackage

// File: rtl/ftb_update_ctrl.sv
// FTB update sequencer: latches one FTQ update, arbitrates the single SRAM port
// against BPU lookups, writes it, then drains the FTQ's stale duplicate request.
// Optional starvation guard: define FTB_UPDATE_STARVE_GUARD_EN.
module ftb_update_ctrl
    import ftb_update_ctrl_pkg::*;
#(
    parameter int unsigned IDX_WIDTH    = 9,
    parameter int unsigned TAG_WIDTH    = 20,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_update_req,
    input  BPupdateInfo_t        i_update_info,
    output logic                 o_update_finished,
    input  logic                 i_lookup_req,
    output logic                 o_lookup_gnt,
    output logic                 o_sram_we,
    output logic [IDX_WIDTH-1:0] o_sram_widx,
    output logic [TAG_WIDTH-1:0] o_sram_wtag,
    output ftbEntry_t            o_sram_wdata,
    output logic                 o_busy
);

    if (STARVE_LIMIT == 0) begin : g_bad_limit
        $error("ftb_update_ctrl: STARVE_LIMIT must be at least 1");
    end

    ftbUpdState_t  state_q, state_d;
    BPupdateInfo_t info_q;
    ftbEntry_t     entry;
    logic          write_win;
    logic          starve_force;

`ifdef FTB_UPDATE_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    logic [STARVE_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt == STARVE_MAX);
`else
    assign starve_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            info_q  <= '0;
`ifdef FTB_UPDATE_STARVE_GUARD_EN
            starve_cnt <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && i_update_req) begin
                info_q <= i_update_info;
            end
`ifdef FTB_UPDATE_STARVE_GUARD_EN
            if (state_q == IDLE && i_update_req) begin
                starve_cnt <= '0;
            end else if (state_q == PEND && !write_win && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        write_win    = 1'b0;
        o_lookup_gnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_lookup_gnt = i_lookup_req;
                if (i_update_req) state_d = PEND;
            end
            PEND: begin
                write_win = !i_lookup_req || starve_force;
                if (write_win) state_d = DRAIN;
                else           o_lookup_gnt = i_lookup_req;
            end
            DRAIN: begin
                o_lookup_gnt = i_lookup_req;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep the port quiet while reset is held, even if the BPU is already requesting.
        o_lookup_gnt = o_lookup_gnt && rst;
    end

    always_comb begin
        entry       = info_q.ftb_update;
        entry.valid = 1'b1;
    end

    assign o_sram_we         = write_win;
    assign o_update_finished = write_win;
    assign o_sram_widx  = write_win ? ftbFuncs#(IDX_WIDTH, TAG_WIDTH)::getIdx(info_q.startAddr) : '0;
    assign o_sram_wtag  = write_win ? ftbFuncs#(IDX_WIDTH, TAG_WIDTH)::getTag(info_q.startAddr) : '0;
    assign o_sram_wdata = write_win ? entry : '0;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: doc/ftb_update_ctrl.md
# ftb_update_ctrl

Sequences FTB update requests from the FTQ commit stage onto the single-ported FTB SRAM, which is shared with BPU prediction lookups. It latches one update, arbitrates the SRAM port against lookups, issues the write, and returns a one-cycle finished pulse to the FTQ. A drain cycle after each write discards the stale duplicate request that the FTQ's registered update-valid produces.

## Interface
- IDX_WIDTH, 9, FTB set-index width; sets = 2**IDX_WIDTH
- TAG_WIDTH, 20, FTB tag width
- STARVE_LIMIT, 4, max consecutive cycles a pending update yields to lookups (guard enabled only)

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- i_update_req  in  1  update valid from FTQ (o_bpu_update)
- i_update_info  in  BPupdateInfo_t  update payload from FTQ (o_BPUupdateInfo)
- o_update_finished  out  1  one-cycle pulse; write issued this cycle (to FTQ i_bpu_update_finished)
- i_lookup_req  in  1  BPU stage-0 lookup request
- o_lookup_gnt  out  1  lookup owns SRAM port this cycle (combinational)
- o_sram_we  out  1  SRAM write enable
- o_sram_widx  out  IDX_WIDTH  write set index
- o_sram_wtag  out  TAG_WIDTH  write tag
- o_sram_wdata  out  ftbEntry_t  write entry (ftb_update field plus valid=1)
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, PEND, DRAIN.
- IDLE: on i_update_req, latch i_update_info and go to PEND; clear starve_cnt. o_lookup_gnt = i_lookup_req.
- PEND: write wins if !i_lookup_req, or if the guard is enabled and starve_cnt == STARVE_LIMIT. On a write win: o_sram_we=1, o_update_finished=1, o_lookup_gnt=0, go to DRAIN. Otherwise: grant the lookup, starve_cnt++ (saturating), stay in PEND.
- DRAIN: ignore i_update_req for exactly one cycle, o_lookup_gnt = i_lookup_req, then go to IDLE.
- i_update_req in PEND or DRAIN is ignored; it is the same entry re-presented.
- Index = latched startAddr[IDX_WIDTH:1]. Tag = startAddr[IDX_WIDTH+TAG_WIDTH:IDX_WIDTH+1]. wdata comes from the latched ftb_update with valid forced to 1.
- o_sram_we is asserted only in PEND. Lookup and write are never granted in the same cycle.
- starve_cnt width = $clog2(STARVE_LIMIT+1).

## Timing
- Reset values: state=IDLE, starve_cnt=0, all outputs 0. o_sram_widx, o_sram_wtag and o_sram_wdata are 0 while o_sram_we=0.
- Reset asserted mid-PEND: the pending update is dropped with no finished pulse. The FTQ re-issues it after reset.
- Latency with no lookups: request sampled in cycle t, write and finished in t+1, DRAIN in t+2, next request accepted in t+3.
- Back-to-back update throughput is one per 3 cycles.
- Request in IDLE coincident with a lookup: the lookup is granted and the request is latched. The earliest write is in t+1.
- Guard enabled, continuous lookups: write occurs in cycle t+1+STARVE_LIMIT.

## Configuration
- FTB_UPDATE_STARVE_GUARD_EN
  - Defined: starve_cnt exists. The update is forced after STARVE_LIMIT yielded cycles, and the lookup is denied that cycle.
  - Undefined: starve_cnt and STARVE_LIMIT are unused. Lookups always win, so the update can wait indefinitely (acceptable only for a dual-ported SRAM model).

## Structure
- Shared frontend package holds:
  - BPupdateInfo_t and ftbEntry_t
  - ftbFuncs::getIdx and ftbFuncs::getTag helpers, parameterised by IDX_WIDTH/TAG_WIDTH
  - state enum ftbUpdState_t
- No sub-module; a single always_ff for state/latch/counter plus one always_comb for grant/write decode.

## Test plan
- No lookups: req pulse in cycle 1 with startAddr=0x8000_1004 -> cycle 2: we=1, widx=0x002 (IDX_WIDTH=9), finished=1; cycle 3: DRAIN; cycle 4: IDLE.
- Stale duplicate: req held high in cycles 1–3 -> exactly one write and one finished pulse; state back to IDLE in cycle 4; a new req in cycle 4 is accepted.
- Guard enabled, STARVE_LIMIT=4, lookup_req held high: req in cycle 1 -> gnt=1 in cycles 1–5; cycle 6: gnt=0, we=1, finished=1.
- Guard disabled, lookup_req high for 10 cycles then low: write occurs in the first cycle lookup_req=0; gnt=1 throughout the 10 cycles.
- Lookup gap: in PEND with starve_cnt=2, lookup drops for one cycle -> write in that cycle; starve_cnt cleared on the next accept.
- Reset asserted asynchronously mid-PEND -> all outputs 0 immediately, no finished pulse; after release, a new req completes normally.
